// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encodings and
// helpers that derive and validate the per-stage slice geometry.
package add_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/add_slice.sv
// Combinational ripple of full-adder cells covering one CHUNK-bit slice.
// Also exposes the carry into the top bit so the last slice can flag overflow.
module add_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    assign s[gi]    = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_add_sub.sv
// WIDTH-bit add/subtract split into STAGES carry-pipelined slices, with a
// single global advance so the whole pipe moves or holds as one unit.
module pipelined_add_sub
  import add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_add_sub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic adv;
  logic zero_reg;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int RW = WIDTH - gi * CHUNK;   // operand bits not yet consumed
    localparam int SW = (gi + 1) * CHUNK;     // sum bits produced so far

    logic [RW-1:0]    op_a;
    logic [RW-1:0]    op_b;
    logic             ci;
    logic             vin;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             cm;
    logic [SW-1:0]    sum_next;
    logic [SW-1:0]    sum_reg;
    logic             vld_reg;
    logic             c_reg;
    logic             ovf_reg;

    if (gi == 0) begin : g_head
      assign op_a     = a;
      assign op_b     = (sub == OP_SUB) ? ~b : b;
      assign ci       = (sub == OP_SUB) ? 1'b1 : cin;
      assign vin      = in_valid;
      assign sum_next = s;
    end else begin : g_body
      assign op_a     = g_stage[gi-1].g_fwd.a_reg;
      assign op_b     = g_stage[gi-1].g_fwd.b_reg;
      assign ci       = g_stage[gi-1].c_reg;
      assign vin      = g_stage[gi-1].vld_reg;
      assign sum_next = {s, g_stage[gi-1].sum_reg};
    end

    add_slice #(.CHUNK(CHUNK)) u_slice (
      .a        (op_a[CHUNK-1:0]),
      .b        (op_b[CHUNK-1:0]),
      .ci       (ci),
      .s        (s),
      .co       (co),
      .c_msb_in (cm)
    );

    // ovf_reg is the signed overflow of the partial word; only the last
    // stage's copy spans the full width and drives the output flag.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_reg <= 1'b0;
        c_reg   <= 1'b0;
        ovf_reg <= 1'b0;
        sum_reg <= '0;
      end else if (adv) begin
        vld_reg <= vin;
        c_reg   <= co;
        ovf_reg <= co ^ cm;
        sum_reg <= sum_next;
      end
    end

    if (gi < STAGES - 1) begin : g_fwd
      logic [RW-CHUNK-1:0] a_reg;
      logic [RW-CHUNK-1:0] b_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_reg <= '0;
          b_reg <= '0;
        end else if (adv) begin
          a_reg <= op_a[RW-1:CHUNK];
          b_reg <= op_b[RW-1:CHUNK];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
    end else if (adv) begin
      zero_reg <= (g_stage[STAGES-1].sum_next == '0);
    end
  end

  assign out_valid = g_stage[STAGES-1].vld_reg;
  assign sum       = g_stage[STAGES-1].sum_reg;
  assign cout      = g_stage[STAGES-1].c_reg;
  assign ovf       = g_stage[STAGES-1].ovf_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Directed-vector bench for pipelined_add_sub (WIDTH=32, STAGES=4): single
// beats with hand-computed results, streaming, backpressure and mid-stream reset.
module tb_pipelined_add_sub;

  localparam int WIDTH  = 32;
  localparam int STAGES = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  int vectors    = 0;
  int miscompares = 0;

  pipelined_add_sub #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result packed as {cout, ovf, zero, sum}.
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mc, input logic ms);
    logic [31:0] bb;
    logic        c0;
    logic [32:0] t;
    logic        v;
    bb = ms ? ~mb : mb;
    c0 = ms ? 1'b1 : mc;
    t  = {1'b0, ma} + {1'b0, bb} + {32'd0, c0};
    v  = (ma[31] == bb[31]) && (t[31] != ma[31]);
    return {t[32], v, (t[31:0] == 32'd0), t[31:0]};
  endfunction

  // Sends one beat and waits (bounded) for its result; lat = 0 on timeout.
  task automatic run_one(input logic [31:0] ta, input logic [31:0] tb_b, input logic tc,
                         input logic ts, output logic [31:0] rs, output logic [2:0] rf,
                         output int lat);
    @(negedge clk);
    a = ta; b = tb_b; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0; rs = '0; rf = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        lat = i; rs = sum; rf = {cout, ovf, zero};
        break;
      end
    end
    $display("txn a=%h b=%h cin=%0d sub=%0d -> sum=%h cout/ovf/zero=%b latency=%0d",
             ta, tb_b, tc, ts, rs, rf, lat);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({out_valid, cout, ovf, zero} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: valid/cout/ovf/zero=%b expected 0000", {out_valid, cout, ovf, zero});
    end
    vectors++;
    if (sum !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_sum: got %h expected 00000000", sum);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_add();
    logic [31:0] va [4] = '{32'd5, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] vb [4] = '{32'd7, 32'd1,         32'd1,         32'h8000_0000};
    logic        vc [4] = '{1'b1,  1'b0,          1'b0,          1'b0};
    logic [31:0] es [4] = '{32'd13, 32'd0,        32'h8000_0000, 32'd0};
    logic [2:0]  ef [4] = '{3'b000, 3'b101,       3'b010,        3'b111};
    logic [31:0] rs;
    logic [2:0]  rf;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_one(va[i], vb[i], vc[i], 1'b0, rs, rf, lat);
      vectors++;
      if (lat != STAGES) begin
        miscompares++;
        $display("FAIL add_latency[%0d]: got %0d expected %0d", i, lat, STAGES);
      end
      vectors++;
      if (rs !== es[i]) begin
        miscompares++;
        $display("FAIL add_sum[%0d]: got %h expected %h", i, rs, es[i]);
      end
      vectors++;
      if (rf !== ef[i]) begin
        miscompares++;
        $display("FAIL add_flags[%0d]: cout/ovf/zero got %b expected %b", i, rf, ef[i]);
      end
    end
  endtask

  task automatic test_subtract();
    logic [31:0] va [5] = '{32'd3, 32'h8000_0000, 32'd5, 32'd0,         32'h7FFF_FFFF};
    logic [31:0] vb [5] = '{32'd5, 32'd1,         32'd5, 32'd1,         32'hFFFF_FFFF};
    logic        vc [5] = '{1'b1,  1'b0,          1'b0,  1'b1,          1'b0};
    logic [31:0] es [5] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [2:0]  ef [5] = '{3'b000,        3'b110,        3'b101, 3'b000,       3'b010};
    logic [31:0] rs;
    logic [2:0]  rf;
    int          lat;
    for (int i = 0; i < 5; i++) begin
      run_one(va[i], vb[i], vc[i], 1'b1, rs, rf, lat);
      vectors++;
      if (rs !== es[i]) begin
        miscompares++;
        $display("FAIL sub_sum[%0d]: got %h expected %h", i, rs, es[i]);
      end
      vectors++;
      if (rf !== ef[i]) begin
        miscompares++;
        $display("FAIL sub_flags[%0d]: cout/ovf/zero got %b expected %b", i, rf, ef[i]);
      end
    end
  endtask

  task automatic test_carry_chain();
    logic [31:0] va [4] = '{32'h00FF_FFFF, 32'h0000_00FF, 32'h0000_FFFF, 32'h00FF_FFFF};
    logic [31:0] vb [4] = '{32'd1,         32'd1,         32'd1,         32'd0};
    logic        vc [4] = '{1'b0,          1'b0,          1'b0,          1'b1};
    logic [31:0] es [4] = '{32'h0100_0000, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000};
    logic [31:0] rs;
    logic [2:0]  rf;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      run_one(va[i], vb[i], vc[i], 1'b0, rs, rf, lat);
      vectors++;
      if (rs !== es[i] || rf !== 3'b000) begin
        miscompares++;
        $display("FAIL carry_chain[%0d]: got sum=%h flags=%b expected sum=%h flags=000",
                 i, rs, rf, es[i]);
      end
    end
  endtask

  task automatic test_full_pipeline();
    logic [31:0] va [8] = '{32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h00FF_FFFF,
                            32'hDEAD_BEEF, 32'd0,         32'h7FFF_FFFF, 32'hAAAA_AAAA};
    logic [31:0] vb [8] = '{32'h1111_1111, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,
                            32'hDEAD_BEEF, 32'd0,         32'h8000_0000, 32'h5555_5555};
    logic        vc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic        vs [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [34:0] exp_r;
    int sent = 0, rcv = 0, cyc = 0;
    while (rcv < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (sent < 8);
      if (sent < 8) begin
        a = va[sent]; b = vb[sent]; cin = vc[sent]; sub = vs[sent];
      end
      #1;
      if (out_valid === 1'b1) begin
        exp_r = model(va[rcv], vb[rcv], vc[rcv], vs[rcv]);
        vectors++;
        if ({cout, ovf, zero, sum} !== exp_r) begin
          miscompares++;
          $display("FAIL stream[%0d]: got %b/%b/%b/%h expected %b/%b/%b/%h", rcv,
                   cout, ovf, zero, sum, exp_r[34], exp_r[33], exp_r[32], exp_r[31:0]);
        end
        $display("txn stream[%0d] sum=%h cout/ovf/zero=%b%b%b", rcv, sum, cout, ovf, zero);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    vectors++;
    if (rcv != 8 || cyc != 8 + STAGES) begin
      miscompares++;
      $display("FAIL stream_throughput: got %0d results in %0d cycles expected 8 in %0d",
               rcv, cyc, 8 + STAGES);
    end
  endtask

  task automatic test_backpressure();
    int sent = 0, rcv = 0, cyc = 0, extra = 0;
    while (rcv < 8 && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      a = 32'(sent); b = 32'(sent); cin = 1'b0; sub = 1'b0;
      #1;
      if (out_valid === 1'b1 && !out_ready) begin
        vectors++;
        if (in_ready !== 1'b0) begin
          miscompares++;
          $display("FAIL stall_in_ready: cycle %0d got %b expected 0", cyc, in_ready);
        end
        vectors++;
        if (sum !== 32'(2 * rcv)) begin
          miscompares++;
          $display("FAIL stall_hold: cycle %0d sum got %h expected %h", cyc, sum, 32'(2 * rcv));
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        vectors++;
        if (sum !== 32'(2 * rcv)) begin
          miscompares++;
          $display("FAIL bp_sum[%0d]: got %h expected %h", rcv, sum, 32'(2 * rcv));
        end
        $display("txn bp[%0d] cycle=%0d sum=%h", rcv, cyc, sum);
        rcv++;
      end
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) extra++;
    end
    vectors++;
    if (rcv != 8 || extra != 0) begin
      miscompares++;
      $display("FAIL bp_count: delivered %0d plus %0d extra expected 8 plus 0", rcv, extra);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] rs;
    logic [2:0]  rf;
    int          lat;
    int          stale = 0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; a = 32'(k + 10); b = 32'd1; cin = 1'b0; sub = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({out_valid, cout, ovf, zero} !== 4'b0000 || sum !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: valid/cout/ovf/zero=%b sum=%h expected 0000 and 0",
               {out_valid, cout, ovf, zero}, sum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    vectors++;
    if (stale != 0) begin
      miscompares++;
      $display("FAIL midreset_stale: got %0d valid cycles expected 0", stale);
    end
    run_one(32'd100, 32'd23, 1'b0, 1'b0, rs, rf, lat);
    vectors++;
    if (lat != STAGES || rs !== 32'd123 || rf !== 3'b000) begin
      miscompares++;
      $display("FAIL midreset_next: got latency=%0d sum=%h flags=%b expected %0d/0000007b/000",
               lat, rs, rf, STAGES);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_carry_chain();
    test_full_pipeline();
    test_backpressure();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
- Parametrised WIDTH-bit adder/subtractor for the arithmetic datapath.
- Built from a chain of full-adder slices, with carry and sum pipelined across STAGES register stages.
- Operands and results move on valid/ready handshakes with full backpressure.
- Produces sum, carry-out, signed-overflow and zero flags; a successor to the single-bit combinational adder cell.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline depth in cycles; slice width CHUNK = WIDTH/STAGES; 1 <= STAGES <= WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept operand beat
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in; used only when sub=0
- sub  in  1  0 = A+B+cin, 1 = A-B (B inverted, carry-in forced 1)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- cout  out  1  carry out of MSB; for sub, 1 means no borrow (A >= B unsigned)
- ovf  out  1  signed two's-complement overflow
- zero  out  1  sum == 0

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, all pipeline data registers = 0.
  - out_valid = 0; sum = 0; cout = 0; ovf = 0; zero = 0.
  - in_ready = 1 once rst_n is high.
- Reset mid-operation: every in-flight beat is discarded; nothing is emitted after release.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv, combinational; there is no combinational path from in_valid to in_ready.
  - Input accepted when in_valid && in_ready.
- On adv, every stage register loads from its predecessor, and stage 0 loads the input beat. A bubble (valid=0) propagates as a bubble. When adv = 0, all registers hold.
- Latency: a beat accepted at edge N appears on out_valid/sum after edge N+STAGES-1 (STAGES cycles of registers including the output register), assuming no stall. Throughput is 1 beat/cycle.
- Stage k (0..STAGES-1):
  - Adds slice [k*CHUNK +: CHUNK] of A and B' (B' = sub ? ~B : B) with the carry registered from stage k-1.
  - Stage 0 carry-in = sub ? 1 : cin.
  - Registers the partial sum bits for slices 0..k, the carry out, and the unconsumed upper operand slices.
- Flags at the final stage:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero = (sum == 0).
  - All flags are registered together with sum and change only with out_valid.
- Output stall: while out_valid && !out_ready, sum/cout/ovf/zero/out_valid hold stable and in_ready = 0.
- Simultaneous accept and emit (in_valid, out_valid, out_ready all 1): both happen in the same cycle; no bubble is inserted.
- Wrap-around: the result is truncated to WIDTH bits; the lost carry is reported only on cout.
- Data registers of bubble stages may hold stale data; only valid-qualified values are observable.

Decomposition:
- Shared package (add_pkg):
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Helper function for CHUNK = WIDTH/STAGES.
  - Elaboration check that WIDTH % STAGES == 0.
- One sub-module: add_slice. Combinational, CHUNK-parameterised ripple of full-adder cells. Ports a, b, ci, s, co, plus c_msb_in (carry into the top bit, used for ovf on the last slice).
- The top level instantiates STAGES add_slice instances and the handshake/register logic.

Test Plan (WIDTH=32, STAGES=4):
- Reset release, out_ready=1, a=5, b=7, cin=1, sub=0 -> 4 cycles later out_valid=1, sum=13, cout=0, ovf=0, zero=0.
- Add wrap: a=0xFFFF_FFFF, b=1, cin=0 -> sum=0, cout=1, zero=1, ovf=0. Signed overflow: a=0x7FFF_FFFF, b=1 -> sum=0x8000_0000, ovf=1, cout=0.
- Subtract: a=3, b=5, sub=1 (cin=1, ignored) -> sum=0xFFFF_FFFE, cout=0, ovf=0. Signed overflow: a=0x8000_0000, b=1, sub=1 -> sum=0x7FFF_FFFF, ovf=1, cout=1.
- Backpressure: stream 8 back-to-back beats (a=i, b=i) with out_ready low for cycles 3..6 -> in_ready low while stalled, output held stable, all 8 sums 2*i delivered in order with none lost or duplicated.
- Carry across every slice boundary: a=0x00FF_FFFF, b=1 -> sum=0x0100_0000. With the pipeline full, every cycle's result matches a reference model.
- Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid=0 immediately, all outputs 0. After release, no stale beat emerges; the next accepted beat returns correctly after 4 cycles.
